// File: rtl/rob_multi_pkg.sv
// Shared types and constants for the multi-port, multi-commit reorder buffer.
// One entry record plus the helper that decides whether an entry must retire alone.
package rob_multi_pkg;

    localparam int ROB_INVALID_ID = 0;
    localparam int DATA_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int REG_W          = 5;
    // Writeback payload carried through the forwarding match: {taken, target, data}.
    localparam int WB_PAY_W       = 1 + ADDR_W + DATA_W;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic              is_branch;
        logic              is_store;
        logic              is_io;
        logic              pred_taken;
        logic              taken;
        logic [REG_W-1:0]  rd;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] rollback_pc;
        logic [ADDR_W-1:0] target;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    // Branches, stores and IO accesses retire only from slot 0 and close the group.
    function automatic logic ends_group(rob_entry_t e);
        return e.is_branch || e.is_store || e.is_io;
    endfunction

endpackage

// File: rtl/rob_wb_forward.sv
// Priority match of one id against all writeback ports; the highest-indexed
// matching port wins. Id 0 never matches.
module rob_wb_forward
    import rob_multi_pkg::*;
#(
    parameter int WB_PORTS = 2,
    parameter int ID_W     = 5,
    parameter int PAY_W    = DATA_W
) (
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*ID_W-1:0]  wb_id,
    input  logic [WB_PORTS*PAY_W-1:0] wb_pay,
    input  logic [ID_W-1:0]           match_id,
    output logic                      hit,
    output logic [PAY_W-1:0]          pay
);

    always_comb begin
        hit = 1'b0;
        pay = '0;
        for (int i = 0; i < WB_PORTS; i++) begin
            if (wb_valid[i] && (match_id != ID_W'(ROB_INVALID_ID)) &&
                (wb_id[i*ID_W +: ID_W] == match_id)) begin
                hit = 1'b1;
                pay = wb_pay[i*PAY_W +: PAY_W];
            end
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocation, multi-port writeback with same-cycle
// operand forwarding, up to COMMIT_W in-order retirements, registered rollback.
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WB_PORTS    = 2,
    parameter int COMMIT_W    = 2,
    parameter int FULL_MARGIN = 5,
    parameter int ID_W        = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       alloc_valid,
    input  logic [REG_W-1:0]           alloc_rd,
    input  logic [ADDR_W-1:0]          alloc_pc,
    input  logic [ADDR_W-1:0]          alloc_rollback_pc,
    input  logic                       alloc_is_branch,
    input  logic                       alloc_is_store,
    input  logic                       alloc_pred_taken,
    output logic [ID_W-1:0]            alloc_id,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [ID_W-1:0]            q1_id,
    input  logic [ID_W-1:0]            q2_id,
    output logic                       q1_ready,
    output logic                       q2_ready,
    output logic [DATA_W-1:0]          q1_value,
    output logic [DATA_W-1:0]          q2_value,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*ID_W-1:0]   wb_id,
    input  logic [WB_PORTS*DATA_W-1:0] wb_data,
    input  logic [WB_PORTS-1:0]        wb_taken,
    input  logic [WB_PORTS*ADDR_W-1:0] wb_target,
    input  logic [ID_W-1:0]            io_mark_id,
    output logic [ID_W-1:0]            head_io_id,
    output logic [COMMIT_W-1:0]        commit_valid,
    output logic [COMMIT_W*ID_W-1:0]   commit_id,
    output logic [COMMIT_W*REG_W-1:0]  commit_rd,
    output logic [COMMIT_W*DATA_W-1:0] commit_data,
    output logic                       bp_valid,
    output logic                       bp_taken,
    output logic [ADDR_W-1:0]          bp_pc,
    output logic                       flush,
    output logic [ADDR_W-1:0]          flush_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rob_entry_t           ents [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;

    logic [WB_PORTS*WB_PAY_W-1:0] wb_pay;
    logic [DEPTH-1:0]             ent_hit;
    logic [WB_PAY_W-1:0]          ent_pay [DEPTH];
    logic                         q1_hit;
    logic                         q2_hit;
    logic [DATA_W-1:0]            q1_fwd;
    logic [DATA_W-1:0]            q2_fwd;
    logic [PTR_W-1:0]             q1_idx;
    logic [PTR_W-1:0]             q2_idx;
    logic [PTR_W-1:0]             io_idx;
    logic [PTR_W-1:0]             slot_idx [COMMIT_W];
    logic [COMMIT_W-1:0]          retire;
    logic [CNT_W-1:0]             n_ret;
    logic                         chain;
    logic                         group_closed;
    logic                         alloc_ok;
    logic                         br_retire;
    logic                         mispredict;
    rob_entry_t                   new_ent;

    for (genvar i = 0; i < WB_PORTS; i++) begin : g_pay
        assign wb_pay[i*WB_PAY_W +: WB_PAY_W] =
            {wb_taken[i], wb_target[i*ADDR_W +: ADDR_W], wb_data[i*DATA_W +: DATA_W]};
    end

    // Entry-update path: one match per entry id.
    for (genvar p = 0; p < DEPTH; p++) begin : g_ent
        rob_wb_forward #(.WB_PORTS(WB_PORTS), .ID_W(ID_W), .PAY_W(WB_PAY_W)) u_fwd (
            .wb_valid (wb_valid),
            .wb_id    (wb_id),
            .wb_pay   (wb_pay),
            .match_id (ID_W'(p + 1)),
            .hit      (ent_hit[p]),
            .pay      (ent_pay[p])
        );
    end

    rob_wb_forward #(.WB_PORTS(WB_PORTS), .ID_W(ID_W), .PAY_W(DATA_W)) u_fwd_q1 (
        .wb_valid (wb_valid),
        .wb_id    (wb_id),
        .wb_pay   (wb_data),
        .match_id (q1_id),
        .hit      (q1_hit),
        .pay      (q1_fwd)
    );

    rob_wb_forward #(.WB_PORTS(WB_PORTS), .ID_W(ID_W), .PAY_W(DATA_W)) u_fwd_q2 (
        .wb_valid (wb_valid),
        .wb_id    (wb_id),
        .wb_pay   (wb_data),
        .match_id (q2_id),
        .hit      (q2_hit),
        .pay      (q2_fwd)
    );

    assign q1_idx   = PTR_W'(q1_id - ID_W'(1));
    assign q2_idx   = PTR_W'(q2_id - ID_W'(1));
    assign io_idx   = PTR_W'(io_mark_id - ID_W'(1));
    assign alloc_id = ID_W'(tail) + ID_W'(1);
    assign full     = count >= CNT_W'(DEPTH - FULL_MARGIN);
    assign alloc_ok = alloc_valid && (count != CNT_W'(DEPTH));

    assign head_io_id = (ents[head].busy && ents[head].is_io) ?
                        ID_W'(head) + ID_W'(1) : ID_W'(ROB_INVALID_ID);

    always_comb begin
        q1_ready = 1'b0;
        q1_value = '0;
        q2_ready = 1'b0;
        q2_value = '0;
        if (q1_id != ID_W'(ROB_INVALID_ID)) begin
            q1_ready = q1_hit ? 1'b1 : ents[q1_idx].ready;
            q1_value = q1_hit ? q1_fwd : ents[q1_idx].data;
        end
        if (q2_id != ID_W'(ROB_INVALID_ID)) begin
            q2_ready = q2_hit ? 1'b1 : ents[q2_idx].ready;
            q2_value = q2_hit ? q2_fwd : ents[q2_idx].data;
        end
    end

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
        assign slot_idx[k] = head + PTR_W'(k);
    end

    // Slot k retires only behind a retiring slot k-1; a group-ending entry stops the chain.
    always_comb begin
        retire       = '0;
        n_ret        = '0;
        chain        = 1'b1;
        group_closed = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (k == 0) begin
                retire[k] = ents[slot_idx[k]].busy &&
                            (ents[slot_idx[k]].ready || ents[slot_idx[k]].is_store);
            end else begin
                retire[k] = chain && !group_closed && ents[slot_idx[k]].busy &&
                            ents[slot_idx[k]].ready && !ends_group(ents[slot_idx[k]]);
            end
            chain = retire[k];
            if (retire[k] && ends_group(ents[slot_idx[k]])) begin
                group_closed = 1'b1;
            end
            if (retire[k]) begin
                n_ret = n_ret + CNT_W'(1);
            end
        end
    end

    assign br_retire  = retire[0] && ents[head].is_branch;
    assign mispredict = br_retire && (ents[head].taken != ents[head].pred_taken);

    always_comb begin
        new_ent             = '0;
        new_ent.busy        = 1'b1;
        new_ent.is_branch   = alloc_is_branch;
        new_ent.is_store    = alloc_is_store;
        new_ent.pred_taken  = alloc_pred_taken;
        new_ent.rd          = alloc_rd;
        new_ent.pc          = alloc_pc;
        new_ent.rollback_pc = alloc_rollback_pc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (rdy && flush)) begin
            for (int p = 0; p < DEPTH; p++) begin
                ents[p] <= '0;
            end
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= '0;
            commit_id    <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
            bp_valid     <= 1'b0;
            bp_taken     <= 1'b0;
            bp_pc        <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
        end else if (rdy) begin
            for (int p = 0; p < DEPTH; p++) begin
                if (ent_hit[p] && ents[p].busy) begin
                    ents[p].ready  <= 1'b1;
                    ents[p].taken  <= ent_pay[p][WB_PAY_W-1];
                    ents[p].target <= ent_pay[p][DATA_W +: ADDR_W];
                    ents[p].data   <= ent_pay[p][DATA_W-1:0];
                end
            end
            if ((io_mark_id != ID_W'(ROB_INVALID_ID)) && ents[io_idx].busy) begin
                ents[io_idx].is_io <= 1'b1;
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (retire[k]) begin
                    ents[slot_idx[k]] <= '0;
                end
                commit_valid[k]                 <= retire[k];
                commit_id[k*ID_W +: ID_W]       <= retire[k] ? ID_W'(slot_idx[k]) + ID_W'(1) : '0;
                commit_rd[k*REG_W +: REG_W]     <= retire[k] ? ents[slot_idx[k]].rd : '0;
                commit_data[k*DATA_W +: DATA_W] <= retire[k] ? ents[slot_idx[k]].data : '0;
            end
            // The tail slot is never among the retiring ones, so this write cannot collide.
            if (alloc_ok) begin
                ents[tail] <= new_ent;
            end
            head     <= head + PTR_W'(n_ret);
            tail     <= tail + PTR_W'(alloc_ok);
            count    <= count + CNT_W'(alloc_ok) - n_ret;
            bp_valid <= br_retire;
            bp_taken <= br_retire && ents[head].taken;
            bp_pc    <= br_retire ? ents[head].pc : '0;
            flush    <= mispredict;
            flush_pc <= !mispredict ? '0 :
                        (ents[head].taken ? ents[head].target : ents[head].rollback_pc);
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: commit results are checked against an in-order
// expected queue, status outputs against constants derived from the stimulus.
module tb_rob_multi;
    import rob_multi_pkg::*;

    localparam int DEPTH       = 16;
    localparam int WB_PORTS    = 2;
    localparam int COMMIT_W    = 2;
    localparam int FULL_MARGIN = 5;
    localparam int ID_W        = 5;
    localparam int SB_W        = ID_W + REG_W + DATA_W;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       rdy;
    logic                       alloc_valid;
    logic [REG_W-1:0]           alloc_rd;
    logic [ADDR_W-1:0]          alloc_pc;
    logic [ADDR_W-1:0]          alloc_rollback_pc;
    logic                       alloc_is_branch;
    logic                       alloc_is_store;
    logic                       alloc_pred_taken;
    logic [ID_W-1:0]            alloc_id;
    logic                       full;
    logic [4:0]                 count;
    logic [ID_W-1:0]            q1_id;
    logic [ID_W-1:0]            q2_id;
    logic                       q1_ready;
    logic                       q2_ready;
    logic [DATA_W-1:0]          q1_value;
    logic [DATA_W-1:0]          q2_value;
    logic [WB_PORTS-1:0]        wb_valid;
    logic [WB_PORTS*ID_W-1:0]   wb_id;
    logic [WB_PORTS*DATA_W-1:0] wb_data;
    logic [WB_PORTS-1:0]        wb_taken;
    logic [WB_PORTS*ADDR_W-1:0] wb_target;
    logic [ID_W-1:0]            io_mark_id;
    logic [ID_W-1:0]            head_io_id;
    logic [COMMIT_W-1:0]        commit_valid;
    logic [COMMIT_W*ID_W-1:0]   commit_id;
    logic [COMMIT_W*REG_W-1:0]  commit_rd;
    logic [COMMIT_W*DATA_W-1:0] commit_data;
    logic                       bp_valid;
    logic                       bp_taken;
    logic [ADDR_W-1:0]          bp_pc;
    logic                       flush;
    logic [ADDR_W-1:0]          flush_pc;

    int checks = 0;
    int errors = 0;
    int nid    = 1;
    logic [SB_W-1:0] exp_q[$];

    rob_multi #(
        .DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W),
        .FULL_MARGIN(FULL_MARGIN), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
        .alloc_rollback_pc(alloc_rollback_pc), .alloc_is_branch(alloc_is_branch),
        .alloc_is_store(alloc_is_store), .alloc_pred_taken(alloc_pred_taken),
        .alloc_id(alloc_id), .full(full), .count(count),
        .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
        .wb_taken(wb_taken), .wb_target(wb_target),
        .io_mark_id(io_mark_id), .head_io_id(head_io_id),
        .commit_valid(commit_valid), .commit_id(commit_id),
        .commit_rd(commit_rd), .commit_data(commit_data),
        .bp_valid(bp_valid), .bp_taken(bp_taken), .bp_pc(bp_pc),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [DATA_W-1:0] data);
        exp_q.push_back({ID_W'(id), REG_W'(id), data});
    endtask

    // Advance one edge, then compare every fresh commit slot against the queue.
    task automatic tick();
        logic            was_active;
        logic [SB_W-1:0] got;
        was_active = rdy && rst_n;
        @(posedge clk);
        #1;
        if (was_active) begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (commit_valid[k]) begin
                    got = {commit_id[k*ID_W +: ID_W], commit_rd[k*REG_W +: REG_W],
                           commit_data[k*DATA_W +: DATA_W]};
                    if (exp_q.size() == 0) chk("sb_unexpected_commit", 64'(got), 64'(0));
                    else chk("sb_commit", 64'(got), 64'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic clr();
        alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0; alloc_rollback_pc = '0;
        alloc_is_branch = 1'b0; alloc_is_store = 1'b0; alloc_pred_taken = 1'b0;
        wb_valid = '0; wb_id = '0; wb_data = '0; wb_taken = '0; wb_target = '0;
        io_mark_id = '0; q1_id = '0; q2_id = '0;
    endtask

    task automatic do_alloc(input logic br, input logic st, input logic pt,
                            input logic [ADDR_W-1:0] rbpc);
        alloc_valid       = 1'b1;
        alloc_rd          = REG_W'(nid);
        alloc_pc          = 32'h1000 + 32'(nid * 4);
        alloc_rollback_pc = rbpc;
        alloc_is_branch   = br;
        alloc_is_store    = st;
        alloc_pred_taken  = pt;
        tick();
        alloc_valid = 1'b0; alloc_is_branch = 1'b0; alloc_is_store = 1'b0;
        alloc_pred_taken = 1'b0;
        nid = (nid % DEPTH) + 1;
    endtask

    task automatic set_wb(input int port, input int id, input logic [DATA_W-1:0] data,
                          input logic tk, input logic [ADDR_W-1:0] tgt);
        wb_valid[port]                    = 1'b1;
        wb_id[port*ID_W +: ID_W]          = ID_W'(id);
        wb_data[port*DATA_W +: DATA_W]    = data;
        wb_taken[port]                    = tk;
        wb_target[port*ADDR_W +: ADDR_W]  = tgt;
    endtask

    initial begin
        logic [DATA_W-1:0] d1, d2, d3, d4, d5;
        logic [DATA_W-1:0] da, db;
        int                ids [DEPTH];

        // Reset
        clr();
        rst_n = 1'b0;
        rdy   = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_alloc_id", 64'(alloc_id), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_commit_valid", 64'(commit_valid), 64'(0));
        chk("rst_flush", 64'(flush), 64'(0));
        chk("rst_bp_valid", 64'(bp_valid), 64'(0));
        chk("rst_head_io", 64'(head_io_id), 64'(0));

        // Two-wide commit of ids 1 and 2
        d1 = $urandom(); d2 = $urandom(); d3 = $urandom();
        do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("alloc3_count", 64'(count), 64'(3));
        chk("alloc3_alloc_id", 64'(alloc_id), 64'(4));
        q1_id = 5'd1;
        #1;
        chk("q1_not_ready", 64'(q1_ready), 64'(0));
        q1_id = '0;
        set_wb(0, 1, d1, 1'b0, 32'h0);
        set_wb(1, 2, d2, 1'b0, 32'h0);
        push(1, d1);
        push(2, d2);
        tick();
        clr();
        chk("wb_edge_no_commit", 64'(commit_valid), 64'(0));
        tick();
        chk("dual_commit_valid", 64'(commit_valid), 64'(2'b11));
        chk("dual_commit_id", 64'(commit_id), 64'({5'd2, 5'd1}));
        chk("dual_commit_count", 64'(count), 64'(1));

        // rdy low: registered outputs hold and the writeback is ignored
        rdy = 1'b0;
        set_wb(0, 3, d3, 1'b0, 32'h0);
        tick();
        chk("hold_commit_valid", 64'(commit_valid), 64'(2'b11));
        chk("hold_count", 64'(count), 64'(1));
        rdy = 1'b1;
        clr();
        q1_id = 5'd3;
        #1;
        chk("hold_wb_ignored", 64'(q1_ready), 64'(0));
        tick();
        chk("idle_commit_valid", 64'(commit_valid), 64'(0));
        set_wb(0, 3, d3, 1'b0, 32'h0);
        push(3, d3);
        tick();
        clr();
        tick();
        chk("single_commit_valid", 64'(commit_valid), 64'(2'b01));

        // Same-cycle forwarding to lookup
        set_wb(1, 4, 32'hDEAD, 1'b0, 32'h0);
        q1_id = 5'd4;
        #1;
        chk("fwd_q1_ready", 64'(q1_ready), 64'(1));
        chk("fwd_q1_value", 64'(q1_value), 64'(32'hDEAD));
        set_wb(0, 4, 32'hAAAA, 1'b0, 32'h0);
        set_wb(1, 4, 32'hBBBB, 1'b0, 32'h0);
        q2_id = 5'd4;
        #1;
        chk("fwd_q2_priority", 64'(q2_value), 64'(32'hBBBB));
        clr();
        set_wb(0, 0, 32'h1234, 1'b0, 32'h0);
        #1;
        chk("id0_ready", 64'(q1_ready), 64'(0));
        chk("id0_value", 64'(q1_value), 64'(0));
        clr();

        // Same id on both ports: port 1 wins in the stored entry
        d4 = $urandom();
        do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        set_wb(0, 4, 32'h4444_0000, 1'b0, 32'h0);
        set_wb(1, 4, d4, 1'b0, 32'h0);
        push(4, d4);
        tick();
        clr();
        q2_id = 5'd4;
        #1;
        chk("stored_q2_ready", 64'(q2_ready), 64'(1));
        chk("stored_q2_value", 64'(q2_value), 64'(d4));
        q2_id = '0;
        tick();
        chk("after_id4_count", 64'(count), 64'(0));

        // Mispredicted taken branch (id 5)
        do_alloc(1'b1, 1'b0, 1'b0, 32'h200);
        set_wb(0, 5, 32'h0, 1'b1, 32'h100);
        push(5, 32'h0);
        tick();
        clr();
        tick();
        chk("br_bp_valid", 64'(bp_valid), 64'(1));
        chk("br_bp_taken", 64'(bp_taken), 64'(1));
        chk("br_bp_pc", 64'(bp_pc), 64'(32'h1014));
        chk("br_flush", 64'(flush), 64'(1));
        chk("br_flush_pc", 64'(flush_pc), 64'(32'h100));
        alloc_valid = 1'b1;
        set_wb(0, 6, 32'h77, 1'b0, 32'h0);
        tick();
        clr();
        nid = 1;
        chk("post_flush_count", 64'(count), 64'(0));
        chk("post_flush_alloc_id", 64'(alloc_id), 64'(1));
        chk("post_flush_flush", 64'(flush), 64'(0));
        chk("post_flush_bp_valid", 64'(bp_valid), 64'(0));
        chk("post_flush_flush_pc", 64'(flush_pc), 64'(0));

        // Correctly predicted branch, then a not-taken mispredict
        do_alloc(1'b1, 1'b0, 1'b1, 32'h300);
        set_wb(0, 1, 32'h0, 1'b1, 32'h180);
        push(1, 32'h0);
        tick();
        clr();
        tick();
        chk("good_br_bp_valid", 64'(bp_valid), 64'(1));
        chk("good_br_flush", 64'(flush), 64'(0));
        do_alloc(1'b1, 1'b0, 1'b1, 32'h444);
        set_wb(0, 2, 32'h0, 1'b0, 32'h999);
        push(2, 32'h0);
        tick();
        clr();
        tick();
        chk("nt_br_bp_taken", 64'(bp_taken), 64'(0));
        chk("nt_br_flush", 64'(flush), 64'(1));
        chk("nt_br_flush_pc", 64'(flush_pc), 64'(32'h444));
        tick();
        nid = 1;
        chk("nt_post_count", 64'(count), 64'(0));

        // Unready ALU, unready store, ready ALU: store retires alone from slot 0
        d1 = $urandom(); d3 = $urandom();
        do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        do_alloc(1'b0, 1'b1, 1'b0, 32'h0);
        do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        set_wb(0, 3, d3, 1'b0, 32'h0);
        tick();
        clr();
        set_wb(0, 1, d1, 1'b0, 32'h0);
        push(1, d1);
        push(2, 32'h0);
        push(3, d3);
        tick();
        clr();
        tick();
        chk("st_a_valid", 64'(commit_valid), 64'(2'b01));
        chk("st_a_id", 64'(commit_id[ID_W-1:0]), 64'(1));
        tick();
        chk("st_b_valid", 64'(commit_valid), 64'(2'b01));
        chk("st_b_id", 64'(commit_id[ID_W-1:0]), 64'(2));
        tick();
        chk("st_c_valid", 64'(commit_valid), 64'(2'b01));
        chk("st_c_id", 64'(commit_id[ID_W-1:0]), 64'(3));

        // IO-flagged head retires alone
        d4 = $urandom(); d5 = $urandom();
        do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        io_mark_id = 5'd4;
        tick();
        io_mark_id = '0;
        chk("head_io_id_set", 64'(head_io_id), 64'(4));
        do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        set_wb(0, 4, d4, 1'b0, 32'h0);
        set_wb(1, 5, d5, 1'b0, 32'h0);
        push(4, d4);
        push(5, d5);
        tick();
        clr();
        tick();
        chk("io_commit_valid", 64'(commit_valid), 64'(2'b01));
        chk("io_head_cleared", 64'(head_io_id), 64'(0));
        tick();
        chk("io_next_valid", 64'(commit_valid), 64'(2'b01));
        chk("io_count", 64'(count), 64'(0));

        // Fill across the wrap point, check full, then drain two per cycle
        for (int j = 0; j < DEPTH; j++) begin
            ids[j] = ((5 + j) % DEPTH) + 1;
            do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
            if (j == 9) chk("full_at_10", 64'(full), 64'(0));
            if (j == 10) chk("full_at_11", 64'(full), 64'(1));
        end
        chk("fill_count", 64'(count), 64'(16));
        chk("fill_alloc_id", 64'(alloc_id), 64'(6));
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("overflow_ignored", 64'(count), 64'(16));
        for (int m = 0; m < DEPTH / 2; m++) begin
            da = $urandom();
            db = $urandom();
            set_wb(0, ids[2*m], da, 1'b0, 32'h0);
            set_wb(1, ids[2*m+1], db, 1'b0, 32'h0);
            push(ids[2*m], da);
            push(ids[2*m+1], db);
            tick();
            clr();
        end
        tick();
        tick();
        chk("drain_count", 64'(count), 64'(0));
        chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));

        // Reset while a flush is pending with five busy entries
        do_alloc(1'b1, 1'b0, 1'b0, 32'h600);
        for (int j = 0; j < 4; j++) do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        set_wb(0, 6, 32'h0, 1'b1, 32'h500);
        push(6, 32'h0);
        do_alloc(1'b0, 1'b0, 1'b0, 32'h0);
        clr();
        tick();
        chk("rf_flush", 64'(flush), 64'(1));
        chk("rf_count", 64'(count), 64'(5));
        rst_n = 1'b0;
        tick();
        chk("rf_flush_cleared", 64'(flush), 64'(0));
        chk("rf_bp_valid", 64'(bp_valid), 64'(0));
        chk("rf_commit_valid", 64'(commit_valid), 64'(0));
        chk("rf_commit_id", 64'(commit_id), 64'(0));
        chk("rf_flush_pc", 64'(flush_pc), 64'(0));
        chk("rf_bp_pc", 64'(bp_pc), 64'(0));
        chk("rf_count_zero", 64'(count), 64'(0));
        chk("rf_alloc_id", 64'(alloc_id), 64'(1));
        rst_n = 1'b1;
        tick();
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
